// File: rtl/demux8_reg_bank.sv
// Eight-slot write bank steered by a 3-bit select, with a valid/ready write port,
// per-slot valid flags, an occupancy count and a one-slot-per-cycle clear sweep.

module demux8_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            v <= 1'b0;
        end else if (wr_en) begin
            q <= d;
            v <= 1'b1;
        end else if (clr_en) begin
            q <= '0;
            v <= 1'b0;
        end
    end
endmodule

module demux8_reg_bank #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [2:0]       w_sel,
    input  logic [WIDTH-1:0] w_data,
    input  logic             clr_start,
    output logic             busy,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [7:0]       q_valid,
    output logic [3:0]       wr_count,
    output logic             full
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state;
    logic [2:0]             idx;
    logic [7:0][WIDTH-1:0]  q_arr;
    logic [7:0]             wr_en;
    logic [7:0]             clr_en;
    logic                   accept;

    assign accept = w_valid && w_ready;

    // Writes only happen in IDLE (w_ready low in CLEAR), so the two enables never collide.
    always_comb begin
        wr_en  = '0;
        clr_en = '0;
        if (accept)
            wr_en[w_sel] = 1'b1;
        if (state == CLEAR)
            clr_en[idx] = 1'b1;
    end

    for (genvar i = 0; i < 8; i++) begin : g_slot
        demux8_slot #(.WIDTH(WIDTH)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en[i]),
            .clr_en (clr_en[i]),
            .d      (w_data),
            .q      (q_arr[i]),
            .v      (q_valid[i])
        );
    end

    assign q0 = q_arr[0];
    assign q1 = q_arr[1];
    assign q2 = q_arr[2];
    assign q3 = q_arr[3];
    assign q4 = q_arr[4];
    assign q5 = q_arr[5];
    assign q6 = q_arr[6];
    assign q7 = q_arr[7];

    assign full = (wr_count == 4'd8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            w_ready  <= 1'b0;
            busy     <= 1'b0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    w_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (accept && !q_valid[w_sel])
                        wr_count <= wr_count + 4'd1;
                    // A same-edge write still lands; the sweep clears it later.
                    if (clr_start) begin
                        state   <= CLEAR;
                        idx     <= '0;
                        w_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (q_valid[idx])
                        wr_count <= wr_count - 4'd1;
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state   <= IDLE;
                        w_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
